// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  localparam int unsigned DEF_FIFO_DEPTH     = 8;
  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_FILTER_LEN     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 5000;

  // PS/2 uses odd parity across the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous scan-code FIFO; drops pushes when full unless a pop frees a slot.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              push_ok_c, pop_ok_c;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop_ok_c  = pop & ~empty;
  assign push_ok_c = push & (~full | pop_ok_c);
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok_c) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok_c && !pop_ok_c)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok_c && pop_ok_c) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: pin conditioning, framing FSM with
// watchdog, sticky error flags and a scan-code FIFO.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   filt_q, filt_d, filt_prev_q;
  logic [FLT_W-1:0]       filt_cnt_q, filt_cnt_d;
  ps2_state_e             state_q, state_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;

  logic clk_s_c, din_c, fall_c, push_c, frame_set_c, parity_set_c, ovf_set_c;
  logic fifo_full, fifo_empty;

  assign clk_s_c = clk_sync_q[SYNC_STAGES-1];
  assign din_c   = data_sync_q[SYNC_STAGES-1];
  assign fall_c  = filt_prev_q & ~filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    filt_d       = filt_q;
    filt_cnt_d   = '0;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wd_d         = '0;
    push_c       = 1'b0;
    frame_set_c  = 1'b0;
    parity_set_c = 1'b0;

    // Filtered level only follows a synchronised value that held FILTER_LEN cycles.
    if (clk_s_c != filt_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) filt_d = clk_s_c;
      else                                      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    if (state_q != ST_IDLE) wd_d = fall_c ? '0 : wd_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fall_c && din_c == START_BIT) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_c) begin
          shift_d   = {din_c, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_c) begin
          par_d   = din_c;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_c) begin
          state_d = ST_IDLE;
          if (din_c != STOP_BIT)                  frame_set_c  = 1'b1;
          else if (!odd_parity_ok(shift_q, par_q)) parity_set_c = 1'b1;
          else                                    push_c       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !fall_c && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d     = ST_IDLE;
      wd_d        = '0;
      frame_set_c = 1'b1;
    end
  end

  // A full FIFO still accepts the byte when a pop lands in the same cycle.
  assign ovf_set_c = push_c & fifo_full & ~rd_en;
  assign ovf_d     = ovf_set_c    | (ovf_q  & ~err_clr);
  assign perr_d    = parity_set_c | (perr_q & ~err_clr);
  assign ferr_d    = frame_set_c  | (ferr_q & ~err_clr);

  ps2_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (rd_en),
    .wdata (shift_q),
    .rdata (data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign ready      = ~fifo_empty;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, monitor checks popped bytes.
module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd_en, err_clr;
  logic [7:0] data;
  logic       ready;
  logic [3:0] count;
  logic       overflow, parity_err, frame_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .err_clr(err_clr), .data(data), .ready(ready),
    .count(count), .overflow(overflow), .parity_err(parity_err),
    .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every honoured pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_en && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no entry", data);
      end else begin
        check("pop_data", 32'(data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  // Stop bit with rd_en landing on the cycle the filtered fall is seen.
  task automatic stop_bit_with_pop();
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (6) @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (13) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic ps2_glitch();
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop,
                            input bit pop_at_stop, input int glitch_after);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(b[i]);
      if (i == glitch_after) ps2_glitch();
    end
    ps2_bit((~^b) ^ flip_par);
    if (pop_at_stop) stop_bit_with_pop();
    else             ps2_bit(stop);
    ps2_data = 1'b1;
  endtask

  task automatic pop_one();
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) check("pop_wait_ready", 32'(ready), 32'd1);
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Valid byte
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0, -1);
    check("valid_ready", 32'(ready), 32'd1);
    check("valid_count", 32'(count), 32'd1);
    check("valid_head", 32'(data), 32'h1C);
    check("valid_flags", 32'({overflow, parity_err, frame_err}), 32'd0);
    pop_one();
    check("valid_pop_ready", 32'(ready), 32'd0);
    check("valid_pop_count", 32'(count), 32'd0);

    // Parity error, then a good frame while the flag is sticky
    send_frame(8'h1C, 1'b1, 1'b1, 0, -1);
    check("perr_flag", 32'(parity_err), 32'd1);
    check("perr_count", 32'(count), 32'd0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 0, -1);
    check("perr_next_count", 32'(count), 32'd1);
    check("perr_sticky", 32'(parity_err), 32'd1);
    pop_one();
    check("perr_sticky_after_pop", 32'(parity_err), 32'd1);
    clear_err();
    check("perr_cleared", 32'(parity_err), 32'd0);

    // Overflow: ninth byte dropped
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b0, 1'b1, 0, -1);
    end
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    clear_err();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO with a pop in the stop-bit fall cycle
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 1, -1);
    check("fullpop_count", 32'(count), 32'd8);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    repeat (8) pop_one();
    check("drain_ready", 32'(ready), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Watchdog abandons a partial frame
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    repeat (4800) @(posedge clk);
    #1;
    check("wd_not_yet", 32'(frame_err), 32'd0);
    repeat (300) @(posedge clk);
    #1;
    check("wd_frame_err", 32'(frame_err), 32'd1);
    check("wd_count", 32'(count), 32'd0);
    clear_err();
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0, -1);
    check("wd_recover_count", 32'(count), 32'd1);
    check("wd_recover_ferr", 32'(frame_err), 32'd0);
    pop_one();

    // Bad stop bit
    send_frame(8'h1C, 1'b0, 1'b0, 0, -1);
    check("stop_frame_err", 32'(frame_err), 32'd1);
    check("stop_parity_err", 32'(parity_err), 32'd0);
    check("stop_count", 32'(count), 32'd0);
    clear_err();

    // Short ps2_clk glitch mid-frame must not shift a bit
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0, 3);
    check("glitch_count", 32'(count), 32'd1);
    check("glitch_flags", 32'({overflow, parity_err, frame_err}), 32'd0);
    pop_one();

    // Reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 0, -1);
    check("midrst_one_entry", 32'(count), 32'd1);
    check("midrst_flags", 32'({overflow, parity_err, frame_err}), 32'd0);
    pop_one();
    check("midrst_drained", 32'(ready), 32'd0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Parametrised PS/2 device-to-host receiver with a configurable-depth scan-code FIFO, ps2_clk glitch filtering, a frame watchdog and separate sticky error flags. It sits between the PS/2 connector pins and the keyboard scan-code consumer (decoder FSM / display logic) and replaces the fixed 8-entry receiver. On overflow it drops new bytes and never overwrites unread data.

## Interface

- FIFO_DEPTH, 8: scan-code FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; at least 2.
- FILTER_LEN, 4: consecutive equal synchronised ps2_clk samples needed to change the filtered level; at least 1.
- TIMEOUT_CYCLES, 5000: clk cycles without a filtered falling edge before a partial frame is abandoned; at least 2.

Ports:

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin.
- ps2_data  in  1  raw PS/2 data pin.
- rd_en  in  1  pop the FIFO head; ignored when ready=0.
- err_clr  in  1  clears overflow, parity_err and frame_err.
- data  out  8  FIFO head; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a valid byte was dropped because the FIFO was full.
- parity_err  out  1  sticky: a frame was discarded for even parity.
- frame_err  out  1  sticky: bad stop bit or watchdog timeout.

## Operation

- **Input conditioning**
  - Both pins pass through SYNC_STAGES flops; their reset value is 1.
  - The filtered clock (reset value 1) takes the synchronised ps2_clk value once that value has held for FILTER_LEN consecutive cycles.
  - A fall = filtered clock going 1 to 0 and lasts one cycle. ps2_data is sampled from its synchronised value in that cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0, go to DATA and clear the bit index. A fall with data=1 is ignored and no flag is set.
  - DATA: on each fall, shift the bit in LSB-first. After 8 bits, go to PARITY.
  - PARITY: on a fall, latch the bit and go to STOP.
  - STOP: on a fall, decide the frame and go to IDLE. The checks are applied in this priority:
    - stop=0: set frame_err and discard the byte;
    - else even parity over data+parity: set parity_err and discard the byte;
    - else push the byte, or drop it and set overflow if the FIFO is full.
- **Watchdog:** in any state other than IDLE, count clk cycles since the last fall; the counter clears on every fall. When it reaches TIMEOUT_CYCLES, go to IDLE, set frame_err and discard the partial byte.
- **FIFO**
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Full is count==FIFO_DEPTH; empty is count==0.
  - A push and a pop in the same cycle are both honoured and count is unchanged. When full, a simultaneous pop makes room, so the push is accepted and overflow is not set.
  - A pop when empty is a no-op.
- **Error flags:** stay set until err_clr. If err_clr coincides with a new error in the same cycle, the new error wins and the flag remains 1.

## Timing

- **Reset values:** data=0, ready=0, count=0, overflow=0, parity_err=0, frame_err=0; state IDLE, pointers 0.
- **Reset mid-frame:** the partial frame is lost and all state returns immediately to the values above.
- **Edge-detect latency:** a pin falling edge raises the internal fall SYNC_STAGES+FILTER_LEN cycles later, ±1 cycle.
- **Push latency:** the byte is written in the stop-bit fall cycle. data, ready and count update on the next clk edge.
- **Pop:** with rd_en=1 and ready=1 at edge N, data shows the next entry after edge N. ready falls after edge N if that entry was the last one.
- data is a direct read of the registered array at the read pointer and needs no extra read cycle.

## Structure

- **Package ps2_pkg:**
  - FSM state enum;
  - frame constants (DATA_BITS=8, START_BIT=0, STOP_BIT=1);
  - default parameter values.
- **Sub-module ps2_rx_fifo:** parametrised synchronous FIFO with push, pop, wdata, rdata, full, empty and count ports. It is instantiated once; all framing, filtering and error logic stays in the top module.

## Test plan

- **Valid byte:** one frame of 0x1C with parity 0 and stop 1. Expect data=0x1C, ready=1, count=1, all flags 0; one rd_en pulse then gives ready=0, count=0.
- **Parity error:** 0x1C sent with parity 1. Expect parity_err=1, count=0. A following valid 0xF0 frame gives data=0xF0 and parity_err stays 1 until err_clr.
- **Overflow and drop:** with FIFO_DEPTH=8, send 0x01..0x09 without reading. Expect count=8, overflow=1; eight pops return 0x01..0x08 and 0x09 is never seen.
- **Full with simultaneous pop:** with the FIFO full, assert rd_en in the stop-bit fall cycle of 0x55. Expect count to stay 8, overflow=0, and 0x55 to be the last entry.
- **Watchdog timeout:** send a start bit plus 4 data bits, then idle. After TIMEOUT_CYCLES expect frame_err=1 and state IDLE; a full 0x1C frame afterwards is received correctly.
- **Glitch and reset mid-frame:**
  - A ps2_clk low pulse of FILTER_LEN−1 cycles produces no bit shift.
  - Asserting rst after 3 data bits, then sending 0x1C, yields exactly one entry 0x1C.
